// File: rtl/ram_sweep_ctrl.sv
// Single-port synchronous RAM with a write/read-back sweep sequencer and an idle-time external port.
// Optional macro RAM_SWEEP_INV_PASS_EN adds a second sweep pass using the inverted pattern.
module ram_sweep_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              verify_only,
    input  logic [DATA_W-1:0] seed,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_din,
    input  logic              ext_wren,
    input  logic              ext_rden,
    output logic [DATA_W-1:0] Dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_valid;
    logic [DATA_W-1:0] seed_q;
    logic              verify_q;
    logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_SWEEP_INV_PASS_EN
    logic pass_idx;
`else
    localparam logic pass_idx = 1'b0;
`endif

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] base,
                                              input logic [ADDR_W-1:0] a);
        return base + DATA_W'(a);
    endfunction

    // External port only reaches the RAM in IDLE, and a start in the same cycle drops it.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = cnt;
        ram_wdata = pat(seed_q, cnt) ^ {DATA_W{pass_idx}};
        case (state)
            IDLE: begin
                if (!start) begin
                    ram_we    = ext_wren;
                    ram_re    = ext_rden & ~ext_wren;
                    ram_addr  = ext_addr;
                    ram_wdata = ext_din;
                end
            end
            WRITE:   ram_we = 1'b1;
            READ:    ram_re = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    Dout <= '0;
        else if (ram_re) Dout <= mem[ram_addr];
    end

    assign exp_word = pat(seed_q, cmp_addr) ^ {DATA_W{pass_idx}};
    assign mismatch = cmp_valid && (Dout != exp_word);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cmp_addr       <= '0;
            cmp_valid      <= 1'b0;
            seed_q         <= '0;
            verify_q       <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
`ifdef RAM_SWEEP_INV_PASS_EN
            pass_idx       <= 1'b0;
`endif
        end else begin
            cmp_valid <= 1'b0;
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                pass      <= 1'b0;
                if (err_count == '0) first_err_addr <= cmp_addr;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        verify_q       <= verify_only;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b1;
                        cnt            <= '0;
`ifdef RAM_SWEEP_INV_PASS_EN
                        pass_idx       <= 1'b0;
`endif
                        state          <= verify_only ? READ : WRITE;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= READ;
                end
                READ: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= cnt;
                    cnt       <= cnt + 1'b1;
                    if (cnt == '1) state <= DRAIN;
                end
                DRAIN: begin
`ifdef RAM_SWEEP_INV_PASS_EN
                    // First pass's DRAIN doubles as the turnaround into the inverted pass.
                    if (!pass_idx) begin
                        pass_idx <= 1'b1;
                        state    <= verify_q ? READ : WRITE;
                    end else begin
                        state <= DONE;
                    end
`else
                    state <= DONE;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Directed bench for ram_sweep_ctrl (DATA_W=8, ADDR_W=4) with a sweep-level reference model.
// Latencies count clock edges from the start-sampling edge inclusive.
module tb_ram_sweep_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

`ifdef RAM_SWEEP_INV_PASS_EN
    localparam int unsigned NPASS    = 2;
    localparam int unsigned LAT_WV   = 67;
    localparam int unsigned LAT_VO   = 35;
    localparam logic [7:0]  RD5      = 8'hEA;
    localparam int unsigned VO_ERR   = 18;
    localparam int unsigned VO_FIRST = 0;
    localparam logic [7:0]  RD7      = 8'hF8;
`else
    localparam int unsigned NPASS    = 1;
    localparam int unsigned LAT_WV   = 34;
    localparam int unsigned LAT_VO   = 18;
    localparam logic [7:0]  RD5      = 8'h15;
    localparam int unsigned VO_ERR   = 2;
    localparam int unsigned VO_FIRST = 3;
    localparam logic [7:0]  RD7      = 8'h07;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          verify_only;
    logic [DW-1:0] seed;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_din;
    logic          ext_wren;
    logic          ext_rden;
    logic [DW-1:0] Dout;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW+1:0] err_count;
    logic [AW-1:0] first_err_addr;

    ram_sweep_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .verify_only(verify_only),
        .seed(seed), .ext_addr(ext_addr), .ext_din(ext_din), .ext_wren(ext_wren),
        .ext_rden(ext_rden), .Dout(Dout), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 Clk = ~Clk;

    // reference model state
    logic [7:0]  m_mem [DEPTH];
    logic [7:0]  exp_dout;
    logic        exp_busy, exp_done, exp_pass;
    int unsigned exp_err, exp_first;
    bit          chk_en, chk_res, chk_dout;

    // literal pins, requested by the stimulus and checked by the compare process
    bit          lit_lat_en, lit_res_en, lit_dout_en;
    int unsigned lit_lat, lit_err, lit_first, meas_lat;
    logic        lit_pass;
    logic [7:0]  lit_dout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, want);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (chk_res) begin
                check("pass", 32'(pass), 32'(exp_pass));
                check("err_count", 32'(err_count), exp_err);
                check("first_err_addr", 32'(first_err_addr), exp_first);
            end
            if (chk_dout) check("Dout", 32'(Dout), 32'(exp_dout));
        end
        if (lit_lat_en) check("latency", meas_lat, lit_lat);
        if (lit_res_en) begin
            check("pin_err", 32'(err_count), lit_err);
            check("pin_first", 32'(first_err_addr), lit_first);
            check("pin_pass", 32'(pass), 32'(lit_pass));
        end
        if (lit_dout_en) check("pin_dout", 32'(Dout), 32'(lit_dout));
    end

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic pin_sweep(input int unsigned lat, input int unsigned e,
                             input int unsigned f, input logic p);
        lit_lat = lat; lit_err = e; lit_first = f; lit_pass = p;
        lit_lat_en = 1; lit_res_en = 1;
        step();
        lit_lat_en = 0; lit_res_en = 0;
    endtask

    task automatic pin_dout(input logic [7:0] v);
        lit_dout = v; lit_dout_en = 1;
        step();
        lit_dout_en = 0;
    endtask

    task automatic ext_write(input logic [3:0] a, input logic [7:0] d);
        ext_wren = 1; ext_addr = a; ext_din = d;
        step();
        ext_wren = 0;
        m_mem[a] = d;
    endtask

    task automatic ext_read(input logic [3:0] a);
        ext_rden = 1; ext_addr = a;
        step();
        ext_rden = 0;
        exp_dout = m_mem[a];
    endtask

    task automatic ext_both(input logic [3:0] a, input logic [7:0] d);
        ext_wren = 1; ext_rden = 1; ext_addr = a; ext_din = d;
        step();
        ext_wren = 0; ext_rden = 0;
        m_mem[a] = d;
    endtask

    // Sweep outcome is computed up front from the pattern rule; timing from the pass count.
    task automatic run_sweep(input logic [7:0] sd, input logic vo, input bit poke);
        int unsigned work, lat, errs, first;
        bit          got;
        logic [7:0]  p;
        work = vo ? DEPTH : 2 * DEPTH;
        lat  = NPASS * (work + 1) + 1;
        errs = 0; first = 0; got = 0;
        for (int unsigned ps = 0; ps < NPASS; ps++) begin
            if (!vo)
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    p = sd + 8'(a);
                    m_mem[a] = (ps == 1) ? ~p : p;
                end
            for (int unsigned a = 0; a < DEPTH; a++) begin
                p = sd + 8'(a);
                if (ps == 1) p = ~p;
                if (m_mem[a] != p) begin
                    errs++;
                    if (!got) first = a;
                    got = 1;
                end
            end
        end
        // external access in the start cycle must be dropped
        start = 1; verify_only = vo; seed = sd;
        ext_wren = 1; ext_rden = 1; ext_addr = 0; ext_din = 8'h55;
        step();
        start = 0; ext_wren = 0; ext_rden = 0;
        meas_lat = 0;
        for (int unsigned c = 1; c <= lat; c++) begin
            if (done === 1'b1 && meas_lat == 0) meas_lat = c;
            exp_busy = (c < lat);
            exp_done = (c == lat);
            chk_res  = (c == lat);
            chk_dout = (c == lat);
            if (c == lat) begin
                exp_err = errs; exp_first = first; exp_pass = (errs == 0);
                exp_dout = m_mem[DEPTH-1];
            end
            if (poke && c == 5) begin
                start = 1; ext_wren = 1; ext_addr = 1; ext_din = 8'h66;
            end else if (poke && c == 6) begin
                start = 0; ext_wren = 0;
            end
            step();
        end
        exp_busy = 0; exp_done = 0; chk_res = 1; chk_dout = 1;
    endtask

    initial begin
        Reset_n = 0; start = 0; verify_only = 0; seed = '0;
        ext_addr = '0; ext_din = '0; ext_wren = 0; ext_rden = 0;
        for (int unsigned a = 0; a < DEPTH; a++) m_mem[a] = '0;
        exp_dout = '0; exp_busy = 0; exp_done = 0; exp_pass = 0;
        exp_err = 0; exp_first = 0;
        lit_lat_en = 0; lit_res_en = 0; lit_dout_en = 0;
        lit_lat = 0; lit_err = 0; lit_first = 0; lit_pass = 0; lit_dout = '0; meas_lat = 0;
        chk_en = 1; chk_res = 1; chk_dout = 1;

        repeat (3) step();
        Reset_n = 1;
        repeat (20) step();

        // clean write+verify sweep, with start/ext_wren poked while busy
        run_sweep(8'h10, 1'b0, 1'b1);
        pin_sweep(LAT_WV, 0, 0, 1'b1);
        ext_read(4'd5);
        pin_dout(RD5);

        // corrupt two words, then verify only
        ext_write(4'd3, 8'hFF);
        ext_write(4'd9, 8'h00);
        run_sweep(8'h10, 1'b1, 1'b0);
        pin_sweep(LAT_VO, VO_ERR, VO_FIRST, 1'b0);

        // simultaneous write and read: write wins, Dout holds
        ext_both(4'd2, 8'hAA);
        step();
        ext_read(4'd2);
        pin_dout(8'hAA);

        // asynchronous reset while in READ of a write+verify sweep
        start = 1; verify_only = 0; seed = 8'h5A;
        step();
        start = 0;
        exp_busy = 1; chk_res = 0; chk_dout = 0;
        repeat (DEPTH + 4) step();
        for (int unsigned a = 0; a < DEPTH; a++) m_mem[a] = 8'h5A + 8'(a);
        Reset_n = 0;
        exp_busy = 0; exp_done = 0; exp_pass = 0; exp_err = 0; exp_first = 0;
        exp_dout = '0; chk_res = 1; chk_dout = 1;
        step();
        step();
        Reset_n = 1;
        step();
        run_sweep(8'h3C, 1'b0, 1'b0);
        pin_sweep(LAT_WV, 0, 0, 1'b1);

        run_sweep(8'h00, 1'b0, 1'b0);
        pin_sweep(LAT_WV, 0, 0, 1'b1);
        ext_read(4'd7);
        pin_dout(RD7);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
